// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: shifts bytes out MSB-first at clk_8f and inserts the
// idle/comma byte whenever no data is offered at a word boundary.
module paralelo_serial_tx #(
    parameter logic [7:0]  IDLE_BYTE = 8'hBC,
    parameter int unsigned MIN_IDLE  = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       serial_out,
    output logic       word_start,
    output logic       data_active
);

    typedef enum logic {
        StSync,
        StActive
    } state_e;

    localparam logic [3:0] LastIdle = 4'(MIN_IDLE - 1);

    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_idle_cnt;
    state_e     r_state;
    logic       r_word_is_data;

    logic w_boundary;
    logic w_transfer;

    assign w_boundary = (r_bit_cnt == 3'd7);
    // Data may already be accepted at the last sync boundary, so MIN_IDLE idle words precede it.
    assign ready_out  = w_boundary & ((r_state == StActive) | (r_idle_cnt == LastIdle));
    assign w_transfer = ready_out & valid_in;

    assign serial_out  = r_shreg[7];
    assign word_start  = (r_bit_cnt == 3'd0);
    assign data_active = r_word_is_data;

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_shreg        <= IDLE_BYTE;
            r_bit_cnt      <= 3'd0;
            r_idle_cnt     <= 4'd0;
            r_state        <= StSync;
            r_word_is_data <= 1'b0;
        end else if (!w_boundary) begin
            r_shreg   <= {r_shreg[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end else begin
            r_bit_cnt <= 3'd0;
            if (w_transfer) begin
                r_shreg        <= data_in;
                r_word_is_data <= 1'b1;
            end else begin
                r_shreg        <= IDLE_BYTE;
                r_word_is_data <= 1'b0;
            end
            if (r_state == StSync) begin
                if (r_idle_cnt == LastIdle) begin
                    r_state <= StActive;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: per-word expectations are queued when stimulus is
// driven and compared bit by bit on the falling edge.
module tb_paralelo_serial_tx;

    localparam int TbMinIdle = 4;
    localparam logic [7:0] TbIdle = 8'hBC;

    typedef struct packed {
        logic ser;
        logic act;
        logic ws;
        logic rdy;
    } exp_t;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       serial_out;
    logic       word_start;
    logic       data_active;

    logic       reset1;
    logic [7:0] data1;
    logic       valid1;
    logic       ready1;
    logic       serial1;
    logic       wstart1;
    logic       active1;

    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en   = 1'b0;
    exp_t sb_q[$];

    int         k;
    logic [7:0] pend_byte;
    logic       pend_act;

    always #5 clk_8f = ~clk_8f;

    paralelo_serial_tx #(
        .IDLE_BYTE (TbIdle),
        .MIN_IDLE  (TbMinIdle)
    ) u_dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .serial_out  (serial_out),
        .word_start  (word_start),
        .data_active (data_active)
    );

    paralelo_serial_tx #(
        .IDLE_BYTE (TbIdle),
        .MIN_IDLE  (1)
    ) u_dut_min1 (
        .clk_8f      (clk_8f),
        .reset       (reset1),
        .data_in     (data1),
        .valid_in    (valid1),
        .ready_out   (ready1),
        .serial_out  (serial1),
        .word_start  (wstart1),
        .data_active (active1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_8f) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                check("sb_depth", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("serial_out", {31'd0, serial_out}, {31'd0, e.ser});
                check("data_active", {31'd0, data_active}, {31'd0, e.act});
                check("word_start", {31'd0, word_start}, {31'd0, e.ws});
                check("ready_out", {31'd0, ready_out}, {31'd0, e.rdy});
            end
        end
    end

    // Called just after the edge that starts word k; queues word k and offers a byte for k+1.
    task automatic slot(input logic v, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.ser = pend_byte[7-i];
            e.act = pend_act;
            e.ws  = (i == 0);
            e.rdy = (i == 7) && (k + 1 >= TbMinIdle);
            sb_q.push_back(e);
        end
        valid_in = v;
        data_in  = v ? d : 8'($urandom);
        if (v && (k + 1 >= TbMinIdle)) begin
            pend_byte = d;
            pend_act  = 1'b1;
        end else begin
            pend_byte = TbIdle;
            pend_act  = 1'b0;
        end
        k++;
        repeat (8) @(posedge clk_8f);
        #1;
    endtask

    // Queues only the first four bits of the pending word, leaving the bench at bit 4.
    task automatic partial_word();
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.ser = pend_byte[7-i];
            e.act = pend_act;
            e.ws  = (i == 0);
            e.rdy = 1'b0;
            sb_q.push_back(e);
        end
        valid_in = 1'b0;
        data_in  = 8'($urandom);
        repeat (4) @(posedge clk_8f);
        #1;
    endtask

    task automatic do_reset(input int n);
        mon_en   = 1'b0;
        reset    = 1'b1;
        valid_in = 1'b0;
        repeat (n) @(posedge clk_8f);
        #1;
        reset     = 1'b0;
        sb_q.delete();
        k         = 0;
        pend_byte = TbIdle;
        pend_act  = 1'b0;
        mon_en    = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        reset1   = 1'b1;
        valid1   = 1'b0;
        data1    = 8'h00;

        // Pure idle after reset: five comma words, ready only at cycles 31 and 39.
        do_reset(3);
        for (int w = 0; w < 5; w++) slot(1'b0, 8'h00);

        // Valid held from cycle 0: only the last sync boundary accepts it.
        do_reset(3);
        for (int w = 0; w < 4; w++) slot(1'b1, 8'hA5);
        slot(1'b0, 8'h00);

        // Back-to-back data with no gap.
        slot(1'b1, 8'hFF);
        slot(1'b1, 8'h00);
        slot(1'b0, 8'h00);

        // One missing word between two data words.
        slot(1'b1, 8'h3C);
        slot(1'b0, 8'h00);
        slot(1'b1, 8'hC3);
        slot(1'b0, 8'h00);

        // Reset mid-word drops 0x5A and repeats the sync sequence.
        slot(1'b1, 8'h5A);
        partial_word();
        do_reset(1);
        for (int w = 0; w < 4; w++) slot(1'b1, 8'h77);
        slot(1'b0, 8'h00);
        slot(1'b0, 8'h00);
        mon_en = 1'b0;

        // MIN_IDLE = 1: first ready at cycle 7, data word in cycles 8..15.
        repeat (2) @(posedge clk_8f);
        #1;
        reset1 = 1'b0;
        valid1 = 1'b1;
        data1  = 8'h81;
        for (int c = 0; c < 16; c++) begin
            logic [7:0] wb;
            @(negedge clk_8f);
            wb = (c < 8) ? TbIdle : 8'h81;
            check("min1_ready", {31'd0, ready1}, {31'd0, (c == 7) || (c == 15)});
            check("min1_serial", {31'd0, serial1}, {31'd0, wb[7 - (c % 8)]});
            check("min1_active", {31'd0, active1}, {31'd0, c >= 8});
            check("min1_wstart", {31'd0, wstart1}, {31'd0, (c % 8) == 0});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
